// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_pkg
//  Brief    : Shared types and constants for the AXI4-Lite master arbiter:
//             sequencer state encoding and AXI response codes.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  // Sequencer states; one AXI4-Lite transaction is in flight outside IDLE
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_RESP_DECERR = 2'b11;

  // Anything other than OKAY is reported as an error; exclusive access has
  // no meaning on AXI4-Lite so EXOKAY is treated as a failure too.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic r;
    case (resp)
      C_RESP_OKAY:   r = 1'b0;
      C_RESP_EXOKAY: r = 1'b1;
      C_RESP_SLVERR: r = 1'b1;
      C_RESP_DECERR: r = 1'b1;
      default:       r = 1'b1;
    endcase
    return r;
  endfunction

  // One-hot completion vector for a requester id
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-input round-robin arbiter. Purely combinational; the
//             last-grant history is held by the parent.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // On contention the requester that was not served last wins; otherwise
  // the single eligible requester is chosen.
  always_comb begin
    grant_valid = |eligible;
    grant_id    = 1'b0;
    if (&eligible) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = eligible[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master_arbiter
//  Brief    : Shares one AXI4-Lite slave between two req/done requesters.
//             Round-robin arbitration, then exactly one read or write
//             transaction at a time on the master-side channels.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // requester side
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy,
  // AXI4-Lite write address channel
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  // AXI4-Lite write data channel
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  // AXI4-Lite write response channel
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  // AXI4-Lite read address channel
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  // AXI4-Lite read data channel
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  state_t              r_state;
  logic                r_grant_id;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_aw_ok;
  logic                r_w_ok;

  logic [1:0]          w_eligible;
  logic                w_grant_valid;
  logic                w_grant_id;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_complete;
  logic                w_w_complete;

  // A requester being acknowledged this cycle is still holding req; mask it
  // so it cannot be re-granted on the strength of a stale request.
  assign w_eligible = req & ~r_done;

  rr_arb2 u_rr_arb2 (
    .eligible    (w_eligible),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_aw_hs       = r_awvalid & AWREADY;
  assign w_w_hs        = r_wvalid & WREADY;
  assign w_aw_complete = r_aw_ok | w_aw_hs;
  assign w_w_complete  = r_w_ok | w_w_hs;

  assign done    = r_done;
  assign rdata   = r_rdata;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);
  assign AWVALID = r_awvalid;
  assign AWADDR  = r_addr;
  assign WVALID  = r_wvalid;
  assign WDATA   = r_wdata;
  assign WSTRB   = {(DATA_W/8){1'b1}};
  assign BREADY  = r_bready;
  assign ARVALID = r_arvalid;
  assign ARADDR  = r_addr;
  assign RREADY  = r_rready;

  // Transaction sequencer: grant, drive one AXI transaction, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 2'b00;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_ok      <= 1'b0;
      r_w_ok       <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_addr       <= w_grant_id ? addr1 : addr0;
            r_wdata      <= w_grant_id ? wdata1 : wdata0;
            if (we[w_grant_id]) begin
              r_state   <= WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_ok   <= 1'b0;
              r_w_ok    <= 1'b0;
            end else begin
              r_state   <= RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          if (r_arvalid && ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (r_rready && RVALID) begin
            r_rready <= 1'b0;
            r_rdata  <= RDATA;
            r_err    <= resp_is_err(RRESP);
            r_done   <= id_to_onehot(r_grant_id);
            r_state  <= IDLE;
          end
        end

        WR_REQ: begin
          // AW and W complete independently, in any order or together
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_ok   <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_ok   <= 1'b1;
          end
          if (w_aw_complete && w_w_complete) begin
            r_aw_ok  <= 1'b0;
            r_w_ok   <= 1'b0;
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (r_bready && BVALID) begin
            r_bready <= 1'b0;
            r_err    <= resp_is_err(BRESP);
            r_done   <= id_to_onehot(r_grant_id);
            r_state  <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_master_arbiter
//  Brief    : Self-checking bench: AXI4-Lite slave with configurable ready /
//             response delays, memory-based reference model, directed and
//             randomized requester traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err, busy;
  logic        AWVALID, AWREADY = 1'b0;
  logic [31:0] AWADDR;
  logic        WVALID, WREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID = 1'b0, BREADY;
  logic [1:0]  BRESP = 2'b00;
  logic        ARVALID, ARREADY = 1'b0;
  logic [31:0] ARADDR;
  logic        RVALID = 1'b0, RREADY;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = 2'b00;

  always #5 clk = ~clk;

  axi_lite_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .err(err), .busy(busy),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave configuration / observations ----------------
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] err_addr = 32'h0000_0EE0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  int          cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // AXI4-Lite slave: drives its inputs at negedge, handshakes complete on posedge
  initial begin : slave
    bit ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    bit ar_seen = 0, aw_seen = 0, w_seen = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] ar_hold = '0, aw_hold = '0, w_hold = '0, rd_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_seen = 0; aw_seen = 0; w_seen = 0;
        continue;
      end
      if (ar_hs) begin
        ARREADY = 0; r_pend = 1; r_cnt = 0; rd_addr = ar_hold;
        last_araddr = ar_hold; ar_seen = 0;
      end
      if (r_hs) RVALID = 0;
      if (aw_hs) begin
        AWREADY = 0; aw_got = 1; last_awaddr = aw_hold; aw_hs_cyc = cyc; aw_seen = 0;
      end
      if (w_hs) begin
        WREADY = 0; w_got = 1; last_wdata = w_hold; w_hs_cyc = cyc; w_seen = 0;
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        if (last_awaddr != err_addr) slave_mem[last_awaddr] = last_wdata;
      end
      if (b_hs) BVALID = 0;

      if (ARVALID) begin
        if (!ar_seen) begin ar_seen = 1; ar_hold = ARADDR; ar_cnt = 0; end
        else check("araddr_stable", ARADDR, ar_hold);
        if (!ARREADY) begin
          if (ar_cnt >= ar_dly) ARREADY = 1; else ar_cnt++;
        end
      end else if (ar_seen) begin
        check("arvalid_held", ARVALID, 1'b1); ar_seen = 0;
      end

      if (AWVALID) begin
        if (!aw_seen) begin aw_seen = 1; aw_hold = AWADDR; aw_cnt = 0; end
        else check("awaddr_stable", AWADDR, aw_hold);
        if (!AWREADY) begin
          if (aw_cnt >= aw_dly) AWREADY = 1; else aw_cnt++;
        end
      end else if (aw_seen) begin
        check("awvalid_held", AWVALID, 1'b1); aw_seen = 0;
      end

      if (WVALID) begin
        if (!w_seen) begin w_seen = 1; w_hold = WDATA; w_cnt = 0; end
        else check("wdata_stable", WDATA, w_hold);
        if (!WREADY) begin
          if (w_cnt >= w_dly) begin WREADY = 1; check("wstrb", WSTRB, 4'hF); end
          else w_cnt++;
        end
      end else if (w_seen) begin
        check("wvalid_held", WVALID, 1'b1); w_seen = 0;
      end

      if (r_pend && !RVALID) begin
        if (r_cnt >= r_dly) begin
          RVALID = 1;
          RDATA  = slave_mem.exists(rd_addr) ? slave_mem[rd_addr] : dflt(rd_addr);
          RRESP  = (rd_addr == err_addr) ? 2'b10 : 2'b00;
          r_pend = 0;
        end else r_cnt++;
      end
      if (b_pend && !BVALID) begin
        if (b_cnt >= b_dly) begin
          BVALID = 1;
          BRESP  = (last_awaddr == err_addr) ? 2'b10 : 2'b00;
          b_pend = 0;
        end else b_cnt++;
      end

      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_last = 1'b1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic wait_done(output logic [1:0] d, output int lat);
    bit got;
    d = 2'b00; lat = 0; got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      lat++;
      if (done != 2'b00) begin d = done; got = 1; break; end
    end
    check("done_seen", got, 1'b1);
  endtask

  // Issue requests from the requesters in pat and serve them to completion
  task automatic run_set(input logic [1:0] pat, input logic [1:0] wv,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         output int lat);
    logic [1:0]  pend, d;
    logic [31:0] a, wd;
    bit          id;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; we = wv; req = pat;
    pend = pat; lat = 0;
    while (pend != 2'b00) begin
      wait_done(d, lat);
      if (d == 2'b00) begin req = 2'b00; return; end
      id = (pend == 2'b11) ? ~ref_last : pend[1];
      check("grant_order", d, id ? 2'b10 : 2'b01);
      a  = id ? a1 : a0;
      wd = id ? d1 : d0;
      check("busy_in_done", busy, 1'b0);
      check("err", err, (a == err_addr));
      if (!wv[id]) begin
        check("rdata", rdata, ref_read(a));
        check("araddr", last_araddr, a);
      end else begin
        check("awaddr", last_awaddr, a);
        check("wdata", last_wdata, wd);
        if (a != err_addr) ref_mem[a] = wd;
      end
      ref_last = id;
      pend[id] = 1'b0;
      req[id]  = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", done, 2'b00);
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return err_addr;
    return 32'h100 + 32'(4 * $urandom_range(0, 7));
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat;
    logic [1:0]  d;
    logic [1:0]  pat, wv;
    logic [31:0] a0, a1, d0, d1;
    bit          exp_id;

    slave_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10]   = 32'hDEAD_BEEF;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // zero-wait read from requester 0
    run_set(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, lat);
    check("rd_latency", lat, 3);

    // write from requester 1, AW accepted two cycles ahead of W
    w_dly = 2;
    run_set(2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h1234_5678, lat);
    check("aw_before_w", w_hs_cyc - aw_hs_cyc, 2);
    check("wr_latency", lat, 5);
    w_dly = 0;

    // req = 11 held for four reads: grants alternate 0,1,0,1
    addr0 = 32'h20; addr1 = 32'h10; we = 2'b00; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, lat);
      exp_id = ~ref_last;
      check("rr_order", d, exp_id ? 2'b10 : 2'b01);
      check("rr_rdata", rdata, ref_read(exp_id ? addr1 : addr0));
      check("rr_busy_gap", busy, 1'b0);
      ref_last = exp_id;
      if (i == 3) req = 2'b00;
      @(negedge clk);
      check("rr_done_pulse", done, 2'b00);
    end

    // error responses and recovery
    run_set(2'b01, 2'b00, err_addr, 32'h0, 32'h0, 32'h0, lat);
    run_set(2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0, lat);
    run_set(2'b10, 2'b10, 32'h0, err_addr, 32'h0, 32'hCAFE_F00D, lat);
    check("wr_zero_wait_latency", lat, 3);

    // ARREADY held off for 5 cycles; addr0 changes after the grant
    ar_dly = 5;
    addr0 = 32'h30; we = 2'b00; req = 2'b01;
    repeat (3) @(negedge clk);
    check("ar_wait_valid", ARVALID, 1'b1);
    addr0 = 32'h99;
    wait_done(d, lat);
    check("ar_wait_done", d, 2'b01);
    check("ar_wait_addr", last_araddr, 32'h30);
    check("ar_wait_rdata", rdata, ref_read(32'h30));
    ref_last = 1'b0;
    req = 2'b00;
    @(negedge clk);
    ar_dly = 0;

    // reset in the middle of a write
    aw_dly = 10; w_dly = 10;
    addr1 = 32'h40; wdata1 = 32'h1111_2222; we = 2'b10; req = 2'b10;
    repeat (3) @(negedge clk);
    check("pre_rst_awvalid", AWVALID, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_awvalid", AWVALID, 1'b0);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_busy_mid", busy, 1'b0);
    check("rst_done_mid", done, 2'b00);
    req = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    ref_last = 1'b1;
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    run_set(2'b11, 2'b00, 32'h104, 32'h108, 32'h0, 32'h0, lat);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      pat = 2'($urandom_range(1, 3));
      wv  = 2'($urandom_range(0, 3));
      a0  = pick_addr();
      a1  = pick_addr();
      d0  = $urandom;
      d1  = $urandom;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      run_set(pat, wv, a0, a1, d0, d1, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_arbiter.md
Name: axi_lite_master_arbiter

Overview:
Shares one AXI4-Lite slave (the RAM's AXI4-Lite slave FSM) between two internal requesters. Each requester has a simple req/done interface. The block arbitrates round-robin, then sequences exactly one AXI4-Lite read or write transaction at a time on the master-side channels. It sits between the clients (CPU-side logic, DMA/test driver) and the slave.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  2  per-requester transaction request; bit i = requester i
we  in  2  per-requester: 1 = write, 0 = read; qualified by req
addr0 / addr1  in  ADDR_W  requester 0/1 address
wdata0 / wdata1  in  DATA_W  requester 0/1 write data
done  out  2  one-cycle completion pulse to the granted requester
rdata  out  DATA_W  read data; valid only while done is nonzero
err  out  1  RESP != OKAY for the completing transaction; valid with done
busy  out  1  transaction in progress (state != IDLE)
AWVALID out 1, AWREADY in 1, AWADDR out ADDR_W
WVALID out 1, WREADY in 1, WDATA out DATA_W, WSTRB out DATA_W/8 (all ones)
BVALID in 1, BREADY out 1, BRESP in 2
ARVALID out 1, ARREADY in 1, ARADDR out ADDR_W
RVALID in 1, RREADY out 1, RDATA in DATA_W, RRESP in 2

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all VALID and READY outputs are 0; done = 0; err = 0; rdata = 0; busy = 0; last_grant = 1, so requester 0 wins first.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: eligible_i = req[i] & ~done[i].
  - A requester whose done is high this cycle is not eligible.
  - Single eligible requester: grant it.
  - Both eligible: grant the requester != last_grant.
  - On the grant edge, latch grant id, we, addr and wdata. Update last_grant. Go to RD_ADDR (we = 0) or WR_REQ (we = 1).
- RD_ADDR: ARVALID = 1, ARADDR = latched addr. On ARVALID & ARREADY, go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID & RREADY:
  - capture RDATA into rdata;
  - err = (RRESP != 2'b00);
  - done[grant] = 1 for the next cycle;
  - return to IDLE.
- WR_REQ: AWVALID and WVALID are both raised on state entry. Each one drops independently after its own handshake, tracked by aw_ok and w_ok flags.
  - Handshakes may occur in the same cycle or in either order.
  - When both flags are set (including the edge that completes the second), go to WR_RESP.
  - AWADDR and WDATA stay stable while the corresponding VALID is high.
- WR_RESP: BREADY = 1. On BVALID & BREADY: err = (BRESP != 2'b00); done[grant] = 1 next cycle; return to IDLE.
- Latency with a zero-wait slave:
  - read: grant edge → ARVALID next cycle → done 3 cycles after the grant edge;
  - write: done 3 cycles after the grant edge if AW and W are accepted together.
- done is a single-cycle pulse coinciding with the IDLE cycle after completion. The minimum gap between back-to-back grants is that IDLE cycle.
- VALIDs never drop before their handshake (AXI rule), regardless of req.
- Changes to req, addr or wdata after the grant are ignored. req deasserted before the grant withdraws the request with no effect.
- Requesters must hold req until they see done, and drop it in the done cycle.
- No timeout: a hung slave stalls the block until reset.
- Reset mid-transaction aborts immediately. All VALIDs go low asynchronously and no done is issued.

Decomposition:
- Shared package axi_lite_pkg:
  - state encoding (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP);
  - RESP constants OKAY = 2'b00, EXOKAY, SLVERR, DECERR.
- Sub-module rr_arb2: 2-input round-robin arbiter. Inputs: eligible, last_grant. Outputs: grant_valid, grant_id (combinational). last_grant is held in the parent.

Test Plan:
- Reset, then req = 01, we = 00, addr0 = 0x10; slave returns RDATA = 0xDEADBEEF, RRESP = 0 → ARADDR = 0x10; done = 01 for 1 cycle; rdata = 0xDEADBEEF; err = 0.
- req = 10, we = 10, addr1 = 0x20, wdata1 = 0x12345678; slave asserts AWREADY 2 cycles before WREADY → AWVALID drops first; WVALID is held until WREADY; BREADY is asserted; done = 10 after the B handshake.
- req = 11 held continuously with reads for 4 transactions → grant order 0, 1, 0, 1; each done pulse is single-cycle; never two grants without an IDLE gap.
- Read with RRESP = 2'b10 → done with err = 1; the next transaction with OKAY → err = 0.
- Slave with ARREADY low for 5 cycles → ARVALID and ARADDR stay stable for all 5 cycles; changing addr0 during the wait has no effect.
- rst_n asserted low in WR_REQ while AWVALID = 1 → AWVALID, WVALID and busy are 0 immediately; after release, req = 11 grants requester 0 first.
